// File: rtl/imm_sign_ext.sv
`default_nettype none
// ============================================================================
//  Module      : imm_sign_ext
//  Description : RV32I immediate generator for the cotm32 decode stage.
//                Pulls the immediate field out of a 32-bit instruction word
//                according to an imm_t select code, sign-extends (or
//                zero-fills) it to XLEN bits and registers the result with a
//                valid flag, one clock of latency, for the execute-stage
//                operand mux.
//
//  Optional    : COTM32_IMM_ZIMM_EN - when defined, select code 3'd5 (IMM_Z)
//                yields the zero-extended CSR zimm field inst[19:15].
//                When undefined, 3'd5 is treated as an unsupported code.
//
//  Parameters  : XLEN      datapath width (only 32 is supported)
//
//  Ports       : i_clk     system clock, rising edge
//                i_rst_n   asynchronous active-low reset
//                i_en      capture enable; low holds all output registers
//                i_valid   i_inst/i_sel carry a live instruction this cycle
//                i_inst    raw instruction word
//                i_sel     immediate format select (imm_t)
//                o_imm     registered immediate
//                o_valid   registered copy of i_valid
//                o_bad_sel registered flag: captured i_sel was unsupported
//
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_sign_ext #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_inst,
    input  logic [2:0]      i_sel,
    output logic [XLEN-1:0] o_imm,
    output logic            o_valid,
    output logic            o_bad_sel
);

    // ------------------------------------------------------------------
    // imm_t encodings
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_U = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;
    localparam logic [2:0] c_IMM_Z = 3'd5;

    // The field extraction below is written against the RV32 bit layout,
    // so any other width cannot be built meaningfully.
    generate
        if (XLEN != 32) begin : g_xlen_unsupported
            $error("imm_sign_ext: XLEN=%0d unsupported, only 32 allowed", XLEN);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-format immediates. Every candidate is formed in parallel from
    // fixed bit positions; the select mux then picks one. Only the
    // instruction bits named by each format feed the result, the opcode
    // field is never looked at.
    // ------------------------------------------------------------------
    logic            w_sign;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_z;

    assign w_sign  = i_inst[31];

    assign w_imm_i = {{(XLEN-12){w_sign}}, i_inst[31:20]};

    assign w_imm_s = {{(XLEN-12){w_sign}}, i_inst[31:25], i_inst[11:7]};

    // Branch offsets are halfword aligned: bit 0 is forced to zero.
    assign w_imm_b = {{(XLEN-13){w_sign}}, i_inst[31], i_inst[7],
                      i_inst[30:25], i_inst[11:8], 1'b0};

    // Upper immediate occupies [31:12], low 12 bits are always zero.
    assign w_imm_u = {i_inst[31:12], 12'b0};

    // Jump offsets are halfword aligned: bit 0 is forced to zero.
    assign w_imm_j = {{(XLEN-21){w_sign}}, i_inst[31], i_inst[19:12],
                      i_inst[20], i_inst[30:21], 1'b0};

    // CSR zimm is an unsigned 5-bit field in the rs1 slot.
    assign w_imm_z = {{(XLEN-5){1'b0}}, i_inst[19:15]};

    // Opcode bits [6:0] are deliberately not part of any immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = &{1'b0, i_inst[6:0]};

    // ------------------------------------------------------------------
    // Select mux and unsupported-code detection. Defaults first, so an
    // unknown or X select lands on the unsupported branch (zero data,
    // flag set) instead of holding a stale value.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_nxt;
    logic            w_bad_nxt;

    always_comb begin
        w_imm_nxt = '0;
        w_bad_nxt = 1'b1;
        case (i_sel)
            c_IMM_I: begin
                w_imm_nxt = w_imm_i;
                w_bad_nxt = 1'b0;
            end
            c_IMM_S: begin
                w_imm_nxt = w_imm_s;
                w_bad_nxt = 1'b0;
            end
            c_IMM_B: begin
                w_imm_nxt = w_imm_b;
                w_bad_nxt = 1'b0;
            end
            c_IMM_U: begin
                w_imm_nxt = w_imm_u;
                w_bad_nxt = 1'b0;
            end
            c_IMM_J: begin
                w_imm_nxt = w_imm_j;
                w_bad_nxt = 1'b0;
            end
`ifdef COTM32_IMM_ZIMM_EN
            c_IMM_Z: begin
                w_imm_nxt = w_imm_z;
                w_bad_nxt = 1'b0;
            end
`endif
            default: begin
                w_imm_nxt = '0;
                w_bad_nxt = 1'b1;
            end
        endcase
    end

`ifndef COTM32_IMM_ZIMM_EN
    // Without the zimm feature the candidate and its code are unused.
    logic w_unused_zimm;
    assign w_unused_zimm = &{1'b0, w_imm_z, c_IMM_Z};
`endif

    // ------------------------------------------------------------------
    // Output registers. Reset values are constants, so nothing on the
    // input side (including an X select) can reach the reset state.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_imm;
    logic            r_valid;
    logic            r_bad_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_imm     <= '0;
            r_valid   <= 1'b0;
            r_bad_sel <= 1'b0;
        end else if (i_en) begin
            // Data is captured regardless of i_valid; only the flag
            // carries validity downstream.
            r_imm     <= w_imm_nxt;
            r_valid   <= i_valid;
            r_bad_sel <= w_bad_nxt;
        end
    end

    assign o_imm     = r_imm;
    assign o_valid   = r_valid;
    assign o_bad_sel = r_bad_sel;

endmodule
`default_nettype wire

// File: tb/tb_imm_sign_ext.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_sign_ext
//  Description : Directed self-checking bench for imm_sign_ext. Expected
//                immediates are hand-decoded from the instruction words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_sign_ext;

    localparam int XLEN = 32;

    logic            clk;
    logic            i_rst_n;
    logic            i_en;
    logic            i_valid;
    logic [XLEN-1:0] i_inst;
    logic [2:0]      i_sel;
    logic [XLEN-1:0] o_imm;
    logic            o_valid;
    logic            o_bad_sel;

    int vectors;
    int miscompares;

    imm_sign_ext #(.XLEN(XLEN)) dut (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_valid   (i_valid),
        .i_inst    (i_inst),
        .i_sel     (i_sel),
        .o_imm     (o_imm),
        .o_valid   (o_valid),
        .o_bad_sel (o_bad_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, let one rising edge pass, then settle before sampling.
    task automatic drive_and_clock(input logic [31:0] inst, input logic [2:0] sel,
                                   input logic valid, input logic en);
        i_inst  = inst;
        i_sel   = sel;
        i_valid = valid;
        i_en    = en;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        // get a nonzero value into the register first
        drive_and_clock(32'h09000913, 3'd0, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'h00000090 || o_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: imm=%h valid=%b, want imm=00000090 valid=1", o_imm, o_valid);
        end
        // assert reset away from any rising edge and check immediately
        #1;
        i_rst_n = 1'b0;
        i_sel   = 3'bxxx;
        #1;
        vectors++;
        if (o_imm !== 32'h0 || o_valid !== 1'b0 || o_bad_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: imm=%h valid=%b bad=%b, want 0/0/0", o_imm, o_valid, o_bad_sel);
        end
        // hold reset across edges with live capture inputs and an X select
        i_en = 1'b1; i_valid = 1'b1; i_inst = 32'hffffffff;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (o_imm !== 32'h0 || o_valid !== 1'b0 || o_bad_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: imm=%h valid=%b bad=%b, want 0/0/0", o_imm, o_valid, o_bad_sel);
        end
        @(negedge clk);
        i_sel   = 3'd0;
        i_rst_n = 1'b1;
    endtask

    task automatic test_formats;
        logic [31:0] insts [5];
        logic [2:0]  sels  [5];
        logic [31:0] exps  [5];
        insts[0] = 32'h09000913; sels[0] = 3'd0; exps[0] = 32'h00000090; // addi
        insts[1] = 32'hff312e23; sels[1] = 3'd1; exps[1] = 32'hfffffffc; // sw
        insts[2] = 32'hff390ce3; sels[2] = 3'd2; exps[2] = 32'hfffffff8; // beq
        insts[3] = 32'h00abca37; sels[3] = 3'd3; exps[3] = 32'h00abc000; // lui
        insts[4] = 32'hffdff06f; sels[4] = 3'd4; exps[4] = 32'hfffffffc; // jal
        for (int k = 0; k < 5; k++) begin
            drive_and_clock(insts[k], sels[k], 1'b1, 1'b1);
            vectors++;
            if (o_imm !== exps[k] || o_valid !== 1'b1 || o_bad_sel !== 1'b0) begin
                miscompares++;
                $display("FAIL format sel=%0d: imm=%h valid=%b bad=%b, want imm=%h valid=1 bad=0",
                         sels[k], o_imm, o_valid, o_bad_sel, exps[k]);
            end
        end
        // all-ones word: B/J bit 0 cleared, U low 12 cleared, I fully sign-extended
        drive_and_clock(32'hffffffff, 3'd2, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'hfffffffe) begin
            miscompares++;
            $display("FAIL b_ones: imm=%h want fffffffe", o_imm);
        end
        drive_and_clock(32'hffffffff, 3'd3, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'hfffff000) begin
            miscompares++;
            $display("FAIL u_ones: imm=%h want fffff000", o_imm);
        end
        // positive S immediate with opcode bits set: 0x7ff, opcode ignored
        drive_and_clock(32'h7e000fff, 3'd1, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'h000007ff) begin
            miscompares++;
            $display("FAIL s_pos: imm=%h want 000007ff", o_imm);
        end
        // J with sign clear: inst[30:21]=1 ->offset 2, [20]=1 ->0x800, [19:12]=0x01 ->0x1000
        drive_and_clock(32'h0030106f, 3'd4, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'h00001802) begin
            miscompares++;
            $display("FAIL j_pos: imm=%h want 00001802", o_imm);
        end
    endtask

    task automatic test_hold;
        drive_and_clock(32'h09000913, 3'd0, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'h00000090) begin
            miscompares++;
            $display("FAIL hold_load: imm=%h want 00000090", o_imm);
        end
        for (int k = 0; k < 3; k++) begin
            drive_and_clock(32'hffdff06f, 3'd4, k[0], 1'b0);
            vectors++;
            if (o_imm !== 32'h00000090 || o_valid !== 1'b1 || o_bad_sel !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cycle %0d: imm=%h valid=%b bad=%b, want 00000090/1/0",
                         k, o_imm, o_valid, o_bad_sel);
            end
        end
        drive_and_clock(32'hffdff06f, 3'd4, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'hfffffffc) begin
            miscompares++;
            $display("FAIL hold_release: imm=%h want fffffffc", o_imm);
        end
    endtask

    task automatic test_bad_sel;
        drive_and_clock(32'hdeadbeef, 3'd6, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'h0 || o_bad_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL sel6: imm=%h bad=%b, want 00000000/1", o_imm, o_bad_sel);
        end
        drive_and_clock(32'hffffffff, 3'd7, 1'b1, 1'b1);
        vectors++;
        if (o_imm !== 32'h0 || o_bad_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL sel7: imm=%h bad=%b, want 00000000/1", o_imm, o_bad_sel);
        end
        drive_and_clock(32'h000f9073, 3'd5, 1'b1, 1'b1);
        vectors++;
`ifdef COTM32_IMM_ZIMM_EN
        if (o_imm !== 32'h0000001f || o_bad_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL sel5_zimm: imm=%h bad=%b, want 0000001f/0", o_imm, o_bad_sel);
        end
`else
        if (o_imm !== 32'h0 || o_bad_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL sel5_nozimm: imm=%h bad=%b, want 00000000/1", o_imm, o_bad_sel);
        end
`endif
        // a supported code afterwards clears the flag
        drive_and_clock(32'h09000913, 3'd0, 1'b1, 1'b1);
        vectors++;
        if (o_bad_sel !== 1'b0 || o_imm !== 32'h00000090) begin
            miscompares++;
            $display("FAIL bad_clear: imm=%h bad=%b, want 00000090/0", o_imm, o_bad_sel);
        end
    endtask

    task automatic test_valid_passthrough;
        drive_and_clock(32'h00abca37, 3'd3, 1'b1, 1'b1);
        vectors++;
        if (o_valid !== 1'b1 || o_imm !== 32'h00abc000) begin
            miscompares++;
            $display("FAIL valid_1a: valid=%b imm=%h, want 1/00abc000", o_valid, o_imm);
        end
        drive_and_clock(32'hff390ce3, 3'd2, 1'b0, 1'b1);
        vectors++;
        if (o_valid !== 1'b0 || o_imm !== 32'hfffffff8) begin
            miscompares++;
            $display("FAIL valid_0: valid=%b imm=%h, want 0/fffffff8", o_valid, o_imm);
        end
        drive_and_clock(32'hff312e23, 3'd1, 1'b1, 1'b1);
        vectors++;
        if (o_valid !== 1'b1 || o_imm !== 32'hfffffffc) begin
            miscompares++;
            $display("FAIL valid_1b: valid=%b imm=%h, want 1/fffffffc", o_valid, o_imm);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_valid = 1'b0;
        i_inst  = '0;
        i_sel   = 3'd0;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (o_imm !== 32'h0 || o_valid !== 1'b0 || o_bad_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL initial_reset: imm=%h valid=%b bad=%b, want 0/0/0", o_imm, o_valid, o_bad_sel);
        end
        @(negedge clk);
        i_rst_n = 1'b1;

        test_reset();
        test_formats();
        test_hold();
        test_bad_sel();
        test_valid_passthrough();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
